// File: rtl/fpu_mc_if.sv
`default_nettype none
// ============================================================================
// fpu_mc_if : operand/result valid-ready bundle for fpu_mc   (Rev 1.0)
// ============================================================================
interface fpu_mc_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/fpu_mc.sv
`default_nettype none
// ============================================================================
// fpu_mc : multi-cycle add/sub/mul/div floating-point unit, truncating rounding
// Rev 1.0
// ============================================================================
module fpu_mc #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic    clk,
  input  logic    rst_n,
  fpu_mc_if.slave io_bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 3;
  localparam int PW = 2 * MAN_W + 2;
  localparam int LW = $clog2(PW);
  localparam int XW = EXP_W + 2 + LW;
  localparam int CW = $clog2(MAN_W + 2);

  localparam logic signed [XW-1:0] BIAS  = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX  = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] UNIT  = XW'(2 * MAN_W);
  localparam logic signed [XW-1:0] SHMAX = XW'(MW);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_EXEC   = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [W-1:0] f_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] f_zero(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  state_t r_state, w_state_nxt;
  logic   w_in_ready, w_out_valid, w_accept;

  logic [W-1:0]          r_a, r_b;
  logic [1:0]            r_op;
  logic                  r_sa, r_sb;
  logic signed [XW-1:0]  r_ea, r_eb;
  logic [MW-1:0]         r_ma, r_mb;
  logic                  r_special;
  logic [W-1:0]          r_sres;
  logic [3:0]            r_sflags;
  logic                  r_sign;
  logic signed [XW-1:0]  r_e;
  logic [PW-1:0]         r_m;
  logic [MAN_W+1:0]      r_rem;
  logic [MAN_W:0]        r_dv;
  logic [MAN_W:0]        r_q;
  logic [CW-1:0]         r_cnt;
  logic [W-1:0]          r_res;
  logic [3:0]            r_flags;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) w_state_nxt = S_UNPACK;
      end
      S_UNPACK: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_special || (r_op != OP_DIV) || (r_cnt == '0)) w_state_nxt = S_NORM;
      end
      S_NORM: w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept         = w_in_ready && io_bus.in_valid;
  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.result    = r_res;
  assign io_bus.flags     = r_flags;

  // ---------------- unpack / classify ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_sb_eff, w_sx;
  logic [MW-1:0]    w_ma, w_mb;

  assign w_ea     = r_a[W-2 -: EXP_W];
  assign w_eb     = r_b[W-2 -: EXP_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
  assign w_sb_eff = r_b[W-1] ^ (r_op == OP_SUB);
  assign w_sx     = r_a[W-1] ^ r_b[W-1];
  // Denormals collapse to zero: no hidden bit, no fraction.
  assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa, 2'b00};
  assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb, 2'b00};

  logic         w_spec;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flg;

  always_comb begin
    w_spec     = 1'b0;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec = 1'b1; w_spec_res = QNAN; w_spec_flg = 4'b1000;
    end else begin
      case (r_op)
        OP_ADD, OP_SUB: begin
          if (w_a_inf && w_b_inf && (r_a[W-1] != w_sb_eff)) begin
            w_spec = 1'b1; w_spec_res = QNAN; w_spec_flg = 4'b1000;
          end else if (w_a_inf) begin
            w_spec = 1'b1; w_spec_res = f_inf(r_a[W-1]);
          end else if (w_b_inf) begin
            w_spec = 1'b1; w_spec_res = f_inf(w_sb_eff);
          end
        end
        OP_MUL: begin
          if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spec = 1'b1; w_spec_res = QNAN; w_spec_flg = 4'b1000;
          end else if (w_a_inf || w_b_inf) begin
            w_spec = 1'b1; w_spec_res = f_inf(w_sx);
          end
        end
        default: begin
          if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_spec = 1'b1; w_spec_res = QNAN; w_spec_flg = 4'b1000;
          end else if (w_a_inf) begin
            w_spec = 1'b1; w_spec_res = f_inf(w_sx);
          end else if (w_b_inf) begin
            w_spec = 1'b1; w_spec_res = f_zero(w_sx);
          end else if (w_b_zero) begin
            w_spec = 1'b1; w_spec_res = f_inf(w_sx); w_spec_flg = 4'b0100;
          end
        end
      endcase
    end
  end

  // ---------------- execute datapaths ----------------
  logic                 w_a_big;
  logic signed [XW-1:0] w_e_big, w_diff;
  logic [MW-1:0]        w_m_big, w_m_sml, w_m_aln;
  logic [MW:0]          w_sum;
  logic [PW-1:0]        w_prod;
  logic                 w_ge;
  logic [MAN_W+1:0]     w_rem_sub;

  assign w_a_big = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_e_big = w_a_big ? r_ea : r_eb;
  assign w_m_big = w_a_big ? r_ma : r_mb;
  assign w_m_sml = w_a_big ? r_mb : r_ma;
  assign w_diff  = w_a_big ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_m_aln = (w_diff >= SHMAX) ? '0 : (w_m_sml >> w_diff);
  assign w_sum   = (r_sa != r_sb) ? ({1'b0, w_m_big} - {1'b0, w_m_aln})
                                  : ({1'b0, w_m_big} + {1'b0, w_m_aln});

  assign w_prod    = PW'(r_ma[MW-1:2]) * PW'(r_mb[MW-1:2]);
  assign w_ge      = r_rem >= {1'b0, r_dv};
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_dv}) : r_rem;

  // ---------------- normalise ----------------
  logic [LW-1:0]        w_lead;
  logic [PW-1:0]        w_norm;
  logic [MAN_W-1:0]     w_frac;
  logic signed [XW-1:0] w_ne;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (r_m[i]) w_lead = LW'(i);
    end
  end

  // Every path parks the unit bit of its mantissa at bit UNIT of r_m.
  assign w_norm = r_m << (LW'(PW - 1) - w_lead);
  assign w_frac = MAN_W'(w_norm >> (PW - 1 - MAN_W));
  assign w_ne   = r_e + $signed({{(XW-LW){1'b0}}, w_lead}) - UNIT;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_special <= 1'b0;
      r_sres    <= '0;
      r_sflags  <= '0;
      r_sign    <= 1'b0;
      r_e       <= '0;
      r_m       <= '0;
      r_rem     <= '0;
      r_dv      <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_flags   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_op    <= io_bus.opcode;
            r_flags <= '0;
          end
        end
        S_UNPACK: begin
          r_sa      <= r_a[W-1];
          r_sb      <= w_sb_eff;
          r_ea      <= {{(XW-EXP_W){1'b0}}, w_ea};
          r_eb      <= {{(XW-EXP_W){1'b0}}, w_eb};
          r_ma      <= w_ma;
          r_mb      <= w_mb;
          r_special <= w_spec;
          r_sres    <= w_spec_res;
          r_sflags  <= w_spec_flg;
          r_rem     <= {1'b0, w_ma[MW-1:2]};
          r_dv      <= w_mb[MW-1:2];
          r_q       <= '0;
          r_cnt     <= CW'(MAN_W + 1);
        end
        S_EXEC: begin
          if (!r_special) begin
            case (r_op)
              OP_MUL: begin
                r_sign <= r_sa ^ r_sb;
                r_e    <= r_ea + r_eb - BIAS;
                r_m    <= w_prod;
              end
              OP_DIV: begin
                r_rem <= w_rem_sub << 1;
                r_q   <= {r_q[MAN_W-1:0], w_ge};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                  r_sign <= r_sa ^ r_sb;
                  r_e    <= r_ea - r_eb + BIAS;
                  r_m    <= PW'({r_q, w_ge}) << (MAN_W - 1);
                end
              end
              default: begin
                r_sign <= (w_sum == '0) ? 1'b0 : (w_a_big ? r_sa : r_sb);
                r_e    <= w_e_big;
                r_m    <= PW'(w_sum) << (MAN_W - 2);
              end
            endcase
          end
        end
        S_NORM: begin
          if (r_special) begin
            r_res   <= r_sres;
            r_flags <= r_sflags;
          end else if (r_m == '0) begin
            r_res   <= f_zero(r_sign);
            r_flags <= 4'b0000;
          end else if (w_ne >= EMAX) begin
            r_res   <= f_inf(r_sign);
            r_flags <= 4'b0010;
          end else if (w_ne[XW-1] || (w_ne == '0)) begin
            r_res   <= f_zero(r_sign);
            r_flags <= 4'b0001;
          end else begin
            r_res   <= {r_sign, w_ne[EXP_W-1:0], w_frac};
            r_flags <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpu_mc.sv
`default_nettype none
// ============================================================================
// tb_fpu_mc : directed-vector scoreboard bench for fpu_mc (EXP_W=8, MAN_W=23)
// Rev 1.0
// ============================================================================
module tb_fpu_mc;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_mc_if #(.W(32)) bus ();
  fpu_mc #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t_rise = 0;
  logic ov_prev = 1'b0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s op%0d: got %h, expected %h", nm, id, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard on every result handshake.
  initial begin : monitor
    exp_t e;
    int   t_a;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ov_prev = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.out_valid && !ov_prev) t_rise = cyc;
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result %h, expected no output", bus.result);
          end else begin
            e = sb.pop_front();
            if (acc_q.size() != 0) t_a = acc_q.pop_front();
            else                   t_a = -1000;
            chk("result", e.id, bus.result, e.res);
            chk("flags", e.id, 32'(bus.flags), 32'(e.flg));
            if (e.lat >= 0) chk("latency", e.id, 32'(t_rise - t_a), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int el);
    int   n;
    exp_t e;
    bus.a        = a;
    bus.b        = b;
    bus.opcode   = op;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op%0d: in_ready got 0, expected 1", id);
      bus.in_valid = 1'b0;
      return;
    end
    e.res = er;
    e.flg = ef;
    e.lat = el;
    e.id  = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding results, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation got no end, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = OP_ADD;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("rst_result", 0, bus.result, 32'h0);
    chk("rst_flags", 0, 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function and boundary vectors.
    issue(1,  OP_ADD, 32'h3FC00000, 32'h40200000, 32'h40800000, 4'b0000, 4);
    issue(2,  OP_SUB, 32'h40400000, 32'h40400000, 32'h00000000, 4'b0000, 4);
    issue(3,  OP_MUL, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 4'b0000, 4);
    issue(4,  OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28);
    issue(5,  OP_DIV, 32'h40E00000, 32'h40000000, 32'h40600000, 4'b0000, 28);
    issue(6,  OP_SUB, 32'h3F800000, 32'h40200000, 32'hBFC00000, 4'b0000, 4);
    issue(7,  OP_MUL, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 4);
    issue(8,  OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 4);
    issue(9,  OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, -1);
    issue(10, OP_DIV, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, -1);
    issue(11, OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, -1);
    issue(12, OP_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, -1);
    issue(13, OP_DIV, 32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, -1);
    drain();

    // Backpressure: result held, new operands refused.
    bus.out_ready = 1'b0;
    issue(20, OP_MUL, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 4'b0000, 4);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.a        = 32'h3FC00000;
    bus.b        = 32'h40200000;
    bus.opcode   = OP_ADD;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 20, 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 20, 32'(bus.in_ready), 32'd0);
      chk("bp_result", 20, bus.result, 32'hC0400000);
      chk("bp_flags", 20, 32'(bus.flags), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", 20, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(21, OP_ADD, 32'h3FC00000, 32'h40200000, 32'h40800000, 4'b0000, 4);
    drain();

    // Reset in the middle of a division discards it.
    issue(30, OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 30, 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 30, 32'(bus.in_ready), 32'd1);
    chk("midrst_result", 30, bus.result, 32'h0);
    chk("midrst_flags", 30, 32'(bus.flags), 32'd0);
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(31, OP_ADD, 32'h3FC00000, 32'h40200000, 32'h40800000, 4'b0000, 4);
    drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
